// File: rtl/dmem_if.sv
// Data-memory bus bundle shared between the pipeline memory controller
// (master) and the memory model or memory system (slave).
interface dmem_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   // The controller drives request, direction, address and store data.
   // It receives read data and the completion strobe.
   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_rdata,
      input  bus_ack
   );

   // The memory side sees the request and answers with data and an ack.
   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_rdata,
      output bus_ack
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the EX/MEM boundary.
// It turns an aligned load or store from EX into a single bus transaction
// and stalls the front of the pipeline until the memory acknowledges or
// the wait times out. Misaligned accesses and rd/wr conflicts never reach
// the bus. They raise a one-cycle exception and load ERR_DATA instead.
module dmem_ctrl #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_mem_rd,
   input  logic        ex_mem_wr,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   output logic        stall,
   output logic [31:0] mem_out,
   output logic        mem_exc,
   dmem_if.master      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Last counter value allowed in BUSY before the transfer is abandoned.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] mem_out_q, mem_out_d;
   logic        mem_exc_q, mem_exc_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        access;
   logic        bad_access;

   // Classify the EX-stage instruction: a clean aligned access or an error.
   always_comb begin
      access     = ex_valid & (ex_mem_rd ^ ex_mem_wr) & (ex_addr[1:0] == 2'b00);
      bad_access = ex_valid & ((ex_mem_rd & ex_mem_wr) |
                               ((ex_mem_rd | ex_mem_wr) & (ex_addr[1:0] != 2'b00)));
   end

   // Next-state and next-output logic for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      mem_out_d   = mem_out_q;
      mem_exc_d   = 1'b0;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (access) begin
               state_d     = BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = ex_mem_wr;
               bus_addr_d  = {ex_addr[31:2], 2'b00};
               bus_wdata_d = ex_wdata;
               cnt_d       = 8'd0;
            end else if (bad_access) begin
               mem_exc_d = 1'b1;
               mem_out_d = ERR_DATA;
            end
         end
         BUSY: begin
            if (bus.bus_ack) begin
               bus_req_d = 1'b0;
               if (!bus_we_q) begin
                  mem_out_d = bus.bus_rdata;
               end
               state_d = DONE;
            end else if (cnt_q == TO_LAST) begin
               bus_req_d = 1'b0;
               mem_out_d = ERR_DATA;
               mem_exc_d = 1'b1;
               state_d   = DONE;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The stall goes high in the same cycle an access is seen, so EX holds the
   // instruction. It is forced low while reset is asserted.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         stall = (state_q == BUSY) | ((state_q == IDLE) & access);
      end
   end

   // All controller state and registered outputs. An asynchronous reset
   // abandons any transfer in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         mem_out_q   <= 32'd0;
         mem_exc_q   <= 1'b0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         mem_out_q   <= mem_out_d;
         mem_exc_q   <= mem_exc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign mem_out       = mem_out_q;
   assign mem_exc       = mem_exc_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with a short timeout, so the abort path
// can be reached within a handful of cycles.
module tb_dmem_ctrl;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_mem_rd;
   logic        ex_mem_wr;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic        stall;
   logic [31:0] mem_out;
   logic        mem_exc;

   int numChecks;
   int numFails;

   int          stallCnt;
   int          reqCnt;
   logic [31:0] seenAddr;
   logic [31:0] seenWdata;
   logic        seenWe;

   dmem_if busIf ();

   dmem_ctrl #(
      .TIMEOUT (4),
      .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ex_valid (ex_valid),
      .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr),
      .ex_addr  (ex_addr),
      .ex_wdata (ex_wdata),
      .stall    (stall),
      .mem_out  (mem_out),
      .mem_exc  (mem_exc),
      .bus      (busIf)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Presents one instruction on the EX-stage inputs.
   task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata);
      ex_valid  = v;
      ex_mem_rd = rd;
      ex_mem_wr = wr;
      ex_addr   = addr;
      ex_wdata  = wdata;
   endtask

   // Moves to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Drives one memory access from IDLE through DONE and stops at the DONE
   // negedge. The memory answers in BUSY cycle index ackAfter. A negative
   // value means it never answers.
   task automatic doAccess(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ackAfter,
                           input logic [31:0] rdata, input string tag);
      bit finished;
      finished  = 1'b0;
      stallCnt  = 0;
      reqCnt    = 0;
      seenAddr  = 32'hFFFF_FFFF;
      seenWdata = 32'hFFFF_FFFF;
      seenWe    = 1'bx;
      applyStimulus(1'b1, rd, wr, addr, wdata);
      for (int c = 0; c < 40; c++) begin
         busIf.bus_ack   = (ackAfter >= 0 && c == ackAfter + 1);
         busIf.bus_rdata = busIf.bus_ack ? rdata : 32'h0;
         @(negedge clk);
         if (stall) stallCnt++;
         if (busIf.bus_req) begin
            reqCnt++;
            seenAddr  = busIf.bus_addr;
            seenWdata = busIf.bus_wdata;
            seenWe    = busIf.bus_we;
         end
         if (c > 0 && !stall) begin
            finished = 1'b1;
            break;
         end
         nextCycle();
      end
      busIf.bus_ack   = 1'b0;
      busIf.bus_rdata = 32'h0;
      checkOutput({tag, "_completes"}, 32'(finished), 32'd1);
      checkOutput({tag, "_reqInDone"}, 32'(busIf.bus_req), 32'd0);
   endtask

   initial begin
      numChecks       = 0;
      numFails        = 0;
      busIf.bus_ack   = 1'b0;
      busIf.bus_rdata = 32'h0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);

      // Reset with an access on the inputs: stall must stay low.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstStall", 32'(stall), 32'd0);
      checkOutput("rstReq", 32'(busIf.bus_req), 32'd0);
      checkOutput("rstWe", 32'(busIf.bus_we), 32'd0);
      checkOutput("rstAddr", busIf.bus_addr, 32'h0);
      checkOutput("rstMemOut", mem_out, 32'h0);
      checkOutput("rstExc", 32'(mem_exc), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      rst = 1'b0;
      nextCycle();

      // Load 0x100 acked in the second BUSY cycle.
      doAccess(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h1234_5678, "ld100");
      checkOutput("ld100Stall", 32'(stallCnt), 32'd3);
      checkOutput("ld100Req", 32'(reqCnt), 32'd2);
      checkOutput("ld100Addr", seenAddr, 32'h100);
      checkOutput("ld100We", 32'(seenWe), 32'd0);
      checkOutput("ld100Data", mem_out, 32'h1234_5678);
      checkOutput("ld100Exc", 32'(mem_exc), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();

      // Store 0x204 acked in the first BUSY cycle; mem_out untouched.
      doAccess(1'b0, 1'b1, 32'h204, 32'hCAFE_F00D, 0, 32'h5555_5555, "st204");
      checkOutput("st204Stall", 32'(stallCnt), 32'd2);
      checkOutput("st204We", 32'(seenWe), 32'd1);
      checkOutput("st204Addr", seenAddr, 32'h204);
      checkOutput("st204Wdata", seenWdata, 32'hCAFE_F00D);
      checkOutput("st204MemOut", mem_out, 32'h1234_5678);
      checkOutput("st204Exc", 32'(mem_exc), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();

      // Misaligned load 0x102: no bus traffic, a single exception pulse.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h102, 32'h0);
      @(negedge clk);
      checkOutput("misStall", 32'(stall), 32'd0);
      checkOutput("misReq", 32'(busIf.bus_req), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("misExc", 32'(mem_exc), 32'd1);
      checkOutput("misMemOut", mem_out, 32'hDEAD_BEEF);
      checkOutput("misReqAfter", 32'(busIf.bus_req), 32'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("misExcOnce", 32'(mem_exc), 32'd0);
      checkOutput("misMemHold", mem_out, 32'hDEAD_BEEF);
      nextCycle();

      // Back-to-back loads 0x10 and 0x14, each acked immediately.
      doAccess(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hAAAA_0010, "ld10");
      checkOutput("ld10Req", 32'(reqCnt), 32'd1);
      checkOutput("ld10Addr", seenAddr, 32'h10);
      checkOutput("ld10Data", mem_out, 32'hAAAA_0010);
      nextCycle();
      doAccess(1'b1, 1'b0, 32'h14, 32'h0, 0, 32'hAAAA_0014, "ld14");
      checkOutput("ld14Stall", 32'(stallCnt), 32'd2);
      checkOutput("ld14Req", 32'(reqCnt), 32'd1);
      checkOutput("ld14Addr", seenAddr, 32'h14);
      checkOutput("ld14Data", mem_out, 32'hAAAA_0014);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("b2bNoDup", 32'(busIf.bus_req), 32'd0);
      nextCycle();

      // Aligned access with both rd and wr set is a conflict.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 32'h0);
      @(negedge clk);
      checkOutput("confStall", 32'(stall), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("confExc", 32'(mem_exc), 32'd1);
      checkOutput("confMemOut", mem_out, 32'hDEAD_BEEF);
      checkOutput("confReq", 32'(busIf.bus_req), 32'd0);
      nextCycle();

      // Load that completes normally, to move mem_out off ERR_DATA.
      doAccess(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0000_0030, "ld30");
      checkOutput("ld30Data", mem_out, 32'h0000_0030);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();

      // Load with no ack: request held for exactly TIMEOUT=4 cycles.
      doAccess(1'b1, 1'b0, 32'h40, 32'h0, -1, 32'h0, "tmo");
      checkOutput("tmoStall", 32'(stallCnt), 32'd5);
      checkOutput("tmoReq", 32'(reqCnt), 32'd4);
      checkOutput("tmoExc", 32'(mem_exc), 32'd1);
      checkOutput("tmoMemOut", mem_out, 32'hDEAD_BEEF);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("tmoExcOnce", 32'(mem_exc), 32'd0);
      nextCycle();

      // Ack arriving in the last allowed BUSY cycle wins over the timeout.
      doAccess(1'b1, 1'b0, 32'h50, 32'h0, 3, 32'h0000_55AA, "late");
      checkOutput("lateReq", 32'(reqCnt), 32'd4);
      checkOutput("lateExc", 32'(mem_exc), 32'd0);
      checkOutput("lateData", mem_out, 32'h0000_55AA);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();

      // A stray ack while IDLE must not touch anything.
      busIf.bus_ack   = 1'b1;
      busIf.bus_rdata = 32'h9999_9999;
      nextCycle();
      busIf.bus_ack   = 1'b0;
      busIf.bus_rdata = 32'h0;
      @(negedge clk);
      checkOutput("strayMemOut", mem_out, 32'h0000_55AA);
      checkOutput("strayReq", 32'(busIf.bus_req), 32'd0);
      checkOutput("strayStall", 32'(stall), 32'd0);
      nextCycle();

      // Reset in the middle of BUSY drops the request and the stall at once.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
      nextCycle();
      @(negedge clk);
      checkOutput("midBusyReq", 32'(busIf.bus_req), 32'd1);
      checkOutput("midBusyStall", 32'(stall), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstReq", 32'(busIf.bus_req), 32'd0);
      checkOutput("midRstStall", 32'(stall), 32'd0);
      checkOutput("midRstExc", 32'(mem_exc), 32'd0);
      checkOutput("midRstMemOut", mem_out, 32'h0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      busIf.bus_ack   = 1'b1;
      busIf.bus_rdata = 32'h7777_7777;
      nextCycle();
      busIf.bus_ack   = 1'b0;
      busIf.bus_rdata = 32'h0;
      @(negedge clk);
      checkOutput("postRstMemOut", mem_out, 32'h0);
      checkOutput("postRstExc", 32'(mem_exc), 32'd0);
      checkOutput("postRstReq", 32'(busIf.bus_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max BUSY cycles waiting for bus_ack before abort (range 1..255).
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: value loaded into mem_out on abort or error.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 ex_valid  in  1  EX stage holds a valid instruction this cycle.
REQ-006 ex_mem_rd  in  1  instruction is a load.
REQ-007 ex_mem_wr  in  1  instruction is a store.
REQ-008 ex_addr  in  32  byte address from ALU.
REQ-009 ex_wdata  in  32  store data.
REQ-010 stall  out  1  holds IF/ID/EX pipeline registers while high.
REQ-011 mem_out  out  32  registered load data, fed to MEM stage mem_out_in.
REQ-012 mem_exc  out  1  one-cycle pulse: misaligned, rd&wr conflict, or timeout.
REQ-013 bus_req  out  1  registered bus request, held until ack or abort.
REQ-014 bus_we  out  1  registered; 1 = store.
REQ-015 bus_addr  out  32  registered word address (ex_addr with [1:0] forced 0).
REQ-016 bus_wdata  out  32  registered store data.
REQ-017 bus_rdata  in  32  read data, valid only in bus_ack cycle.
REQ-018 bus_ack  in  1  one-cycle completion strobe from memory.

Function
REQ-019 FSM states IDLE, BUSY, DONE; exactly one active.
REQ-020 access = ex_valid & (ex_mem_rd ^ ex_mem_wr) & (ex_addr[1:0]==0).
REQ-021 IDLE & access: stall=1 combinationally; capture bus_we/addr/wdata; bus_req=1 next edge; go BUSY.
REQ-022 IDLE & !access: stall=0, bus_req=0, remain IDLE.
REQ-023 IDLE & ex_valid & (rd|wr) & misaligned, or rd&wr both set: no bus access, stall=0, mem_exc pulses next cycle, mem_out=ERR_DATA next cycle.
REQ-024 BUSY: stall=1, bus_req=1, bus_we/addr/wdata stable; timeout counter increments each BUSY cycle.
REQ-025 BUSY & bus_ack: load -> mem_out<=bus_rdata; store -> mem_out unchanged; bus_req<=0; go DONE.
REQ-026 BUSY & counter==TIMEOUT-1 & !bus_ack: bus_req<=0, mem_out<=ERR_DATA, mem_exc pulse in DONE cycle, go DONE.
REQ-027 bus_ack and timeout in same cycle: ack wins, no exception.
REQ-028 DONE: stall=0 (instruction advances at this edge), no new access started; unconditionally go IDLE.
REQ-029 bus_ack outside BUSY is ignored.
REQ-030 Minimum load/store latency: 3 cycles (IDLE, BUSY with ack, DONE); stall high 2 cycles.
REQ-031 mem_out holds last value until the next completed load or error.
REQ-032 Timeout counter is 8 bits, cleared on entry to BUSY; never wraps.

Reset
REQ-033 rst asserted: immediately state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_out=0, mem_exc=0, counter=0.
REQ-034 stall=0 during reset.
REQ-035 Reset mid-BUSY aborts the transfer; no mem_exc; a later bus_ack is ignored.

Verification
REQ-036 Load addr 0x100, ack 2 cycles after bus_req, rdata 0x1234_5678 -> stall high 3 cycles, mem_out=0x1234_5678 in DONE, mem_exc=0.
REQ-037 Store addr 0x204 data 0xCAFE_F00D, ack first BUSY cycle -> bus_we=1, bus_addr=0x204, stall high 2 cycles, mem_out unchanged.
REQ-038 Load addr 0x102 -> no bus_req, stall=0, mem_exc one cycle, mem_out=0xDEAD_BEEF.
REQ-039 TIMEOUT=4, load with no ack -> bus_req high exactly 4 cycles, then DONE, mem_exc pulse, mem_out=0xDEAD_BEEF.
REQ-040 Back-to-back loads 0x10, 0x14 -> second bus_req only after DONE->IDLE; no access skipped or duplicated.
REQ-041 rst asserted in BUSY -> bus_req and stall fall same cycle; late bus_ack leaves mem_out=0.
